// File: rtl/l1_sram_pkg.sv
// Shared defaults and response record for the L1 SRAM port controller.
package l1_sram_pkg;

  localparam int L1_ADDR_WIDTH = 8;
  localparam int L1_DATA_WIDTH = 128;
  localparam int L1_NUM_WMASKS = L1_DATA_WIDTH / 8;
  localparam int L1_TAG_WIDTH  = 4;

  // Outstanding reads allowed between the SRAM read port and the consumer.
  localparam int L1_RSP_CREDITS = 2;

  typedef struct packed {
    logic [L1_DATA_WIDTH-1:0] data;
    logic [L1_TAG_WIDTH-1:0]  tag;
  } rsp_t;

endpackage

// File: rtl/l1_rsp_fifo.sv
// Two-entry response FIFO between the SRAM read capture and the consumer.
// Latency: push visible at head the cycle after the push edge; push+pop same cycle allowed.
// Backpressure: push is dropped when full without a pop; callers reserve space up front.
module l1_rsp_fifo #(
  parameter int WIDTH = 132
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & (count != 2'd0);
  assign do_push = push & ((count != 2'd2) | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head_data  = mem[rd_ptr];
  assign head_valid = (count != 2'd0);

endmodule

// File: rtl/l1_sram_port_ctrl.sv
// Valid/ready front end for a 1W/1R SRAM macro with tagged, in-order read responses.
// Latency: read data captured one cycle after read fire, visible on rsp_* the cycle after.
// Backpressure: rd_ready drops when two reads are owed or on a same-address write; wr_ready is high out of reset.
module l1_sram_port_ctrl
  import l1_sram_pkg::*;
#(
  parameter int ADDR_WIDTH = L1_ADDR_WIDTH,
  parameter int DATA_WIDTH = L1_DATA_WIDTH,
  parameter int NUM_WMASKS = L1_NUM_WMASKS,
  parameter int TAG_WIDTH  = L1_TAG_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_WMASKS-1:0] wr_mask,

  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [TAG_WIDTH-1:0]  rd_tag,

  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [TAG_WIDTH-1:0]  rsp_tag,

  output logic                  sram_clk0,
  output logic                  sram_csb0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,

  output logic                  sram_clk1,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  localparam int RSP_W = DATA_WIDTH + TAG_WIDTH;

  logic                 wr_fire;
  logic                 wr_en;
  logic                 rd_fire;
  logic                 rsp_fire;
  logic                 addr_conflict;
  logic                 credit_ok;
  logic [1:0]           credits_used;
  logic                 rd_inflight;
  logic [TAG_WIDTH-1:0] inflight_tag;
  logic [1:0]           fifo_count;
  logic [RSP_W-1:0]     fifo_head;

  assign sram_clk0 = clk;
  assign sram_clk1 = clk;

  assign wr_ready = ~rst;
  assign wr_fire  = wr_valid & wr_ready;
  assign wr_en    = wr_fire & (|wr_mask);

  // The macro gives undefined read data when both ports hit one word; hold the read back.
  assign addr_conflict = wr_en & (wr_addr == rd_addr);

  // A pop this cycle frees its slot before the new read's data lands two edges later,
  // which is what lets back-to-back reads stream at full rate.
  assign rsp_fire     = rsp_valid & rsp_ready;
  assign credits_used = {1'b0, rd_inflight} + fifo_count - {1'b0, rsp_fire};
  assign credit_ok    = (credits_used < 2'(L1_RSP_CREDITS));

  assign rd_ready = ~rst & credit_ok & ~addr_conflict;
  assign rd_fire  = rd_valid & rd_ready;

  assign sram_csb0   = ~wr_en;
  assign sram_wmask0 = wr_mask;
  assign sram_addr0  = wr_addr;
  assign sram_din0   = wr_data;

  assign sram_csb1  = ~rd_fire;
  assign sram_addr1 = rd_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_inflight  <= 1'b0;
      inflight_tag <= '0;
    end else begin
      rd_inflight <= rd_fire;
      if (rd_fire) begin
        inflight_tag <= rd_tag;
      end
    end
  end

  l1_rsp_fifo #(
    .WIDTH (RSP_W)
  ) u_rsp_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (rd_inflight),
    .push_data  ({sram_dout1, inflight_tag}),
    .pop        (rsp_fire),
    .head_data  (fifo_head),
    .head_valid (rsp_valid),
    .count      (fifo_count)
  );

  assign {rsp_data, rsp_tag} = fifo_head;

endmodule

// File: tb/tb_l1_sram_port_ctrl.sv
// Scoreboard bench for l1_sram_port_ctrl with a behavioural SRAM macro and reference memory.
module tb_l1_sram_port_ctrl;
  import l1_sram_pkg::*;

  localparam int AW = L1_ADDR_WIDTH;
  localparam int DW = L1_DATA_WIDTH;
  localparam int MW = L1_NUM_WMASKS;
  localparam int TW = L1_TAG_WIDTH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [MW-1:0] wr_mask = '0;
  logic          rd_valid = 1'b0;
  logic          rd_ready;
  logic [AW-1:0] rd_addr = '0;
  logic [TW-1:0] rd_tag = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_data;
  logic [TW-1:0] rsp_tag;
  logic          sram_clk0, sram_clk1;
  logic          sram_csb0, sram_csb1;
  logic [MW-1:0] sram_wmask0;
  logic [AW-1:0] sram_addr0, sram_addr1;
  logic [DW-1:0] sram_din0;
  logic [DW-1:0] sram_dout1 = '0;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [DW-1:0] sram_mem [2**AW];
  logic [DW-1:0] ref_mem  [2**AW];
  rsp_t          exp_q [$];

  always #5 clk = ~clk;

  l1_sram_port_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_mask     (wr_mask),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_addr     (rd_addr),
    .rd_tag      (rd_tag),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_tag     (rsp_tag),
    .sram_clk0   (sram_clk0),
    .sram_csb0   (sram_csb0),
    .sram_wmask0 (sram_wmask0),
    .sram_addr0  (sram_addr0),
    .sram_din0   (sram_din0),
    .sram_clk1   (sram_clk1),
    .sram_csb1   (sram_csb1),
    .sram_addr1  (sram_addr1),
    .sram_dout1  (sram_dout1)
  );

  // Macro model: synchronous masked write, read data valid after the sampling edge.
  always @(posedge sram_clk0) begin
    if (!sram_csb0) begin
      for (int b = 0; b < MW; b++) begin
        if (sram_wmask0[b]) sram_mem[sram_addr0][b*8 +: 8] <= sram_din0[b*8 +: 8];
      end
    end
  end

  always @(posedge sram_clk1) begin
    if (!sram_csb1) sram_dout1 <= sram_mem[sram_addr1];
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: handshakes are sampled mid-cycle; the reference memory follows accepted writes.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL rsp_unexpected: got tag %0d data %h, expected no response", rsp_tag, rsp_data);
        end else begin
          rsp_t e;
          e = exp_q.pop_front();
          check("rsp_data", rsp_data, e.data);
          check("rsp_tag", DW'(rsp_tag), DW'(e.tag));
        end
      end
      if (rd_valid && rd_ready) exp_q.push_back('{data: ref_mem[rd_addr], tag: rd_tag});
      if (wr_valid && wr_ready && wr_mask != '0) begin
        for (int b = 0; b < MW; b++) begin
          if (wr_mask[b]) ref_mem[wr_addr][b*8 +: 8] = wr_data[b*8 +: 8];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
    wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [TW-1:0] t);
    int n = 0;
    rd_valid = 1'b1; rd_addr = a; rd_tag = t;
    @(negedge clk);
    while (!rd_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!rd_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL rd_accept_timeout: got rd_ready 0 for 20 cycles, expected acceptance");
    end
    tick();
    rd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name, input logic [DW-1:0] exp_d);
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    check(name, rsp_valid ? rsp_data : 'x, exp_d);
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  initial begin
    int acc;
    for (int i = 0; i < 2**AW; i++) begin
      sram_mem[i] = '0;
      ref_mem[i]  = '0;
    end

    // Reset state, with requests pending on every input.
    wr_valid = 1'b1; wr_mask = '1; rd_valid = 1'b1;
    #2;
    check("rst_wr_ready", DW'(wr_ready), DW'(0));
    check("rst_rd_ready", DW'(rd_ready), DW'(0));
    check("rst_rsp_valid", DW'(rsp_valid), DW'(0));
    check("rst_csb0", DW'(sram_csb0), DW'(1));
    check("rst_csb1", DW'(sram_csb1), DW'(1));
    wr_valid = 1'b0; rd_valid = 1'b0; wr_mask = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Full-word write then tagged read; response appears one edge after capture.
    do_write(8'h05, {16{8'hA5}}, 16'hFFFF);
    do_read(8'h05, 4'd3);
    check("lat_rsp_valid_early", DW'(rsp_valid), DW'(0));
    tick();
    check("lat_rsp_valid", DW'(rsp_valid), DW'(1));
    check("lat_rsp_data", rsp_data, {16{8'hA5}});
    check("lat_rsp_tag", DW'(rsp_tag), DW'(3));
    idle(2);

    // Same-cycle write and read of one address: read waits, then sees new data.
    wr_valid = 1'b1; wr_addr = 8'h10; wr_data = {8{16'hBEEF}}; wr_mask = '1;
    rd_valid = 1'b1; rd_addr = 8'h10; rd_tag = 4'd5;
    @(negedge clk);
    check("conflict_rd_ready", DW'(rd_ready), DW'(0));
    check("conflict_csb0", DW'(sram_csb0), DW'(0));
    tick();
    wr_valid = 1'b0;
    @(negedge clk);
    check("conflict_retry_rd_ready", DW'(rd_ready), DW'(1));
    tick();
    rd_valid = 1'b0;
    wait_rsp("conflict_rsp_data", {8{16'hBEEF}});
    idle(2);

    // Three back-to-back reads with the consumer stalled: only two credits.
    rsp_ready = 1'b0;
    rd_valid = 1'b1; rd_addr = 8'h05; rd_tag = 4'd1;
    @(negedge clk);
    check("stall_rd0_ready", DW'(rd_ready), DW'(1));
    tick();
    rd_addr = 8'h10; rd_tag = 4'd2;
    @(negedge clk);
    check("stall_rd1_ready", DW'(rd_ready), DW'(1));
    tick();
    rd_addr = 8'h05; rd_tag = 4'd4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_rd2_blocked", DW'(rd_ready), DW'(0));
      tick();
    end
    check("stall_fifo_full_valid", DW'(rsp_valid), DW'(1));
    rsp_ready = 1'b1;
    @(negedge clk);
    check("stall_rd2_after_pop", DW'(rd_ready), DW'(1));
    tick();
    rd_valid = 1'b0;
    idle(4);

    // Byte-masked write over zeros, then an all-zero mask that must not touch the macro.
    do_write(8'h20, '0, 16'hFFFF);
    do_write(8'h20, '1, 16'h0001);
    do_read(8'h20, 4'd6);
    wait_rsp("mask_byte0", DW'(8'hFF));
    wr_valid = 1'b1; wr_addr = 8'h20; wr_data = {16{8'h3C}}; wr_mask = '0;
    @(negedge clk);
    check("mask0_wr_ready", DW'(wr_ready), DW'(1));
    check("mask0_csb0", DW'(sram_csb0), DW'(1));
    tick();
    wr_valid = 1'b0;
    do_read(8'h20, 4'd8);
    wait_rsp("mask0_unchanged", DW'(8'hFF));
    idle(2);

    // Reset landing while a read is in flight drops its response.
    do_read(8'h05, 4'd7);
    rst = 1'b1;
    wr_valid = 1'b1; wr_addr = 8'h05; wr_mask = '1; wr_data = '0;
    rd_valid = 1'b1; rd_addr = 8'h06;
    #1;
    check("midrst_rsp_valid", DW'(rsp_valid), DW'(0));
    check("midrst_rsp_data", rsp_data, '0);
    check("midrst_rsp_tag", DW'(rsp_tag), DW'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_csb0", DW'(sram_csb0), DW'(1));
      check("midrst_csb1", DW'(sram_csb1), DW'(1));
      check("midrst_rsp_valid_hold", DW'(rsp_valid), DW'(0));
    end
    wr_valid = 1'b0; rd_valid = 1'b0; wr_mask = '0;
    tick();
    rst = 1'b0;
    idle(2);
    check("postrst_rsp_valid", DW'(rsp_valid), DW'(0));

    // Streaming reads with an always-ready consumer must never stall.
    rsp_ready = 1'b1;
    acc = 0;
    rd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rd_addr = AW'(i); rd_tag = TW'(i);
      @(negedge clk);
      if (rd_ready) acc++;
      tick();
    end
    rd_valid = 1'b0;
    check("stream_accepts", DW'(acc), DW'(20));
    idle(3);

    // Random traffic on a narrow address range to provoke conflicts and credit stalls.
    for (int i = 0; i < 800; i++) begin
      wr_valid  = ($urandom_range(0, 1) == 1);
      wr_addr   = AW'($urandom_range(0, 15));
      wr_data   = {$urandom, $urandom, $urandom, $urandom};
      wr_mask   = ($urandom_range(0, 7) == 0) ? '0 : MW'($urandom);
      rd_valid  = ($urandom_range(0, 2) != 0);
      rd_addr   = AW'($urandom_range(0, 15));
      rd_tag    = TW'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    rsp_ready = 1'b1;
    idle(10);
    check("drain_outstanding", DW'(exp_q.size()), DW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
